// File: rtl/fround_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fround_pipe
// Purpose  : Two-stage pipelined IEEE-754 round-to-integral unit for any
//            EXP_W/MAN_W format. Modes: 00 RNE, 01 trunc, 10 floor, 11 ceil.
//            Valid/ready handshake with backpressure and an inexact flag.
// Ports    : clk, rstn (sync, active low)
//            in_valid/in_ready/in_data/in_mode   - operand side
//            out_valid/out_ready/out_data/out_inexact - result side
//            int_out/int_invalid - signed integer of the result, saturated
//                                  (only when FROUND_INT_OUT_EN is defined)
// Options  : FROUND_INT_OUT_EN - adds the integer output path in stage 2.
// Revision : 1.0 - initial release
// ============================================================================
module fround_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
`ifdef FROUND_INT_OUT_EN
    ,
    parameter int INT_W = 32
`endif
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_data,
    input  logic [1:0]             in_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_data,
    output logic                   out_inexact
`ifdef FROUND_INT_OUT_EN
    ,
    output logic [INT_W-1:0]       int_out,
    output logic                   int_invalid
`endif
);

    localparam int               BIAS       = (1 << (EXP_W - 1)) - 1;
    localparam logic [1:0]       MODE_RNE   = 2'b00;
    localparam logic [1:0]       MODE_TRUNC = 2'b01;
    localparam logic [1:0]       MODE_FLOOR = 2'b10;
    localparam logic [1:0]       MODE_CEIL  = 2'b11;
    localparam logic [EXP_W-1:0] EXP_ONE    = {1'b0, {(EXP_W-1){1'b1}}};
    localparam logic [EXP_W-1:0] EXP_INC    = {{(EXP_W-1){1'b0}}, 1'b1};

    // Whole pipeline moves in lockstep; it only stalls when a result is
    // waiting and the consumer refuses it.
    logic en;
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // ------------------------------------------------------------------
    // Stage 1: decode and rounding decision
    // ------------------------------------------------------------------
    logic             in_sign;
    logic [EXP_W-1:0] in_exp;
    logic [MAN_W-1:0] in_man;
    assign {in_sign, in_exp, in_man} = in_data;

    int               unb_exp;
    logic [MAN_W-1:0] frac_mask;
    logic [MAN_W-1:0] guard_mask;
    logic             guard;
    logic             sticky;
    logic             int_lsb;
    logic             round_up;
    logic             small_one;
    logic [EXP_W-1:0] s1_exp_d;
    logic [MAN_W-1:0] s1_man_d;
    logic [MAN_W:0]   s1_inc_d;
    logic             s1_inexact_d;

    always_comb begin
        unb_exp      = int'(in_exp) - BIAS;
        frac_mask    = '0;
        guard_mask   = '0;
        guard        = 1'b0;
        sticky       = 1'b0;
        int_lsb      = 1'b0;
        round_up     = 1'b0;
        small_one    = 1'b0;
        s1_exp_d     = in_exp;
        s1_man_d     = in_man;
        s1_inc_d     = '0;
        s1_inexact_d = 1'b0;
        if (in_exp == '1) begin
            // NaN gets quieted with payload kept; Inf passes untouched.
            if (in_man != '0) begin
                s1_man_d[MAN_W-1] = 1'b1;
            end
        end else if (unb_exp >= MAN_W) begin
            // No fraction bits left: value is already integral.
        end else if (unb_exp >= 0) begin
            frac_mask  = {MAN_W{1'b1}} >> unb_exp;
            guard_mask = frac_mask & ~(frac_mask >> 1);
            guard      = |(in_man & guard_mask);
            sticky     = |(in_man & (frac_mask >> 1));
            // Integer LSB sits one above the guard; it is the hidden bit
            // when the exponent is exactly zero.
            int_lsb    = |({1'b1, in_man} & {guard_mask, 1'b0});
            case (in_mode)
                MODE_RNE:   round_up = guard & (sticky | int_lsb);
                MODE_TRUNC: round_up = 1'b0;
                MODE_FLOOR: round_up = in_sign & (guard | sticky);
                MODE_CEIL:  round_up = ~in_sign & (guard | sticky);
                default:    round_up = 1'b0;
            endcase
            s1_man_d     = in_man & ~frac_mask;
            s1_inc_d     = round_up ? {guard_mask, 1'b0} : '0;
            s1_inexact_d = guard | sticky;
        end else if (in_exp == '0 && in_man == '0) begin
            // Signed zero passes through exactly.
        end else begin
            // |x| < 1 (including subnormals): result is 0 or 1.0.
            case (in_mode)
                MODE_RNE:   small_one = (unb_exp == -1) && (in_man != '0);
                MODE_TRUNC: small_one = 1'b0;
                MODE_FLOOR: small_one = in_sign;
                MODE_CEIL:  small_one = ~in_sign;
                default:    small_one = 1'b0;
            endcase
            s1_exp_d     = small_one ? EXP_ONE : '0;
            s1_man_d     = '0;
            s1_inexact_d = 1'b1;
        end
    end

    logic             r1_valid;
    logic             r1_sign;
    logic [EXP_W-1:0] r1_exp;
    logic [MAN_W-1:0] r1_man;
    logic [MAN_W:0]   r1_inc;
    logic             r1_inexact;

    // ------------------------------------------------------------------
    // Stage 2: apply increment, renormalise on carry, pack
    // ------------------------------------------------------------------
    // Adding into {1,man} overflows exactly when the man field overflows,
    // so the carry is the top bit of a MAN_W+1 wide sum.
    logic [MAN_W:0]   frac_sum;
    logic             carry;
    logic [EXP_W-1:0] res_exp;
    logic [MAN_W-1:0] res_man;

    assign frac_sum = {1'b0, r1_man} + r1_inc;
    assign carry    = frac_sum[MAN_W];
    assign res_exp  = carry ? r1_exp + EXP_INC : r1_exp;
    assign res_man  = carry ? '0 : frac_sum[MAN_W-1:0];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r1_valid    <= 1'b0;
            r1_sign     <= 1'b0;
            r1_exp      <= '0;
            r1_man      <= '0;
            r1_inc      <= '0;
            r1_inexact  <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_inexact <= 1'b0;
        end else if (en) begin
            r1_valid    <= in_valid;
            r1_sign     <= in_sign;
            r1_exp      <= s1_exp_d;
            r1_man      <= s1_man_d;
            r1_inc      <= s1_inc_d;
            r1_inexact  <= s1_inexact_d;
            out_valid   <= r1_valid;
            out_data    <= {r1_sign, res_exp, res_man};
            out_inexact <= r1_inexact;
        end
    end

`ifdef FROUND_INT_OUT_EN
    localparam logic [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};

    int                       res_unb;
    logic [MAN_W+INT_W:0]     int_wide;
    logic [INT_W-1:0]         int_mag;
    logic [INT_W-1:0]         int_d;
    logic                     int_inv_d;

    always_comb begin
        res_unb   = int'(res_exp) - BIAS;
        int_wide  = '0;
        int_mag   = '0;
        int_d     = '0;
        int_inv_d = 1'b0;
        if (res_exp == '1) begin
            // NaN saturates positive; Inf saturates by sign.
            int_inv_d = 1'b1;
            int_d     = (r1_sign && res_man == '0) ? INT_MIN : INT_MAX;
        end else if (res_unb < 0) begin
            int_d = '0;
        end else if (res_unb >= INT_W - 1) begin
            // Only -2^(INT_W-1) is representable at this magnitude.
            if (r1_sign && res_unb == INT_W - 1 && res_man == '0) begin
                int_d = INT_MIN;
            end else begin
                int_inv_d = 1'b1;
                int_d     = r1_sign ? INT_MIN : INT_MAX;
            end
        end else begin
            int_wide = {{INT_W{1'b0}}, 1'b1, res_man} << res_unb;
            int_mag  = INT_W'(int_wide >> MAN_W);
            int_d    = r1_sign ? -int_mag : int_mag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            int_out     <= '0;
            int_invalid <= 1'b0;
        end else if (en) begin
            int_out     <= int_d;
            int_invalid <= int_inv_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fround_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fround_pipe
// Purpose  : Self-checking bench for fround_pipe (fp32 defaults). Directed
//            vectors, backpressure stream, mid-flight reset, random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fround_pipe;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_inexact;
`ifdef FROUND_INT_OUT_EN
    logic [31:0] int_out;
    logic        int_invalid;
`endif

    always #5 clk = ~clk;

    fround_pipe dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_mode     (in_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_inexact (out_inexact)
`ifdef FROUND_INT_OUT_EN
        ,
        .int_out     (int_out),
        .int_invalid (int_invalid)
`endif
    );

    int n_asserts = 0;
    int n_fail    = 0;
    int n_out     = 0;

    logic [31:0] q_data[$];
    logic        q_inx[$];
    logic [31:0] q_int[$];
    logic        q_inv[$];

    // Occupancy of the two stages as seen from the handshake rules.
    bit m_v1 = 1'b0;
    bit m_v2 = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference rounding on the numeric value: split the significand into
    // integer quotient and remainder by the weight of one integer unit.
    function automatic void ref_round(input logic [31:0] x, input logic [1:0] md,
                                      output logic [31:0] r, output logic inx);
        int     e;
        longint sig, unit, q, rem;
        bit     up;
        e   = int'(x[30:23]) - 127;
        sig = longint'({1'b1, x[22:0]});
        r   = x;
        inx = 1'b0;
        up  = 1'b0;
        if (x[30:23] == 8'hFF) begin
            if (x[22:0] != 23'd0) r[22] = 1'b1;
        end else if (e >= 23) begin
            r = x;
        end else if (e >= 0) begin
            unit = longint'(1) << (23 - e);
            q    = sig / unit;
            rem  = sig % unit;
            case (md)
                2'b00:   up = (2 * rem > unit) || (2 * rem == unit && q % 2 == 1);
                2'b01:   up = 1'b0;
                2'b10:   up = x[31] && rem != 0;
                default: up = !x[31] && rem != 0;
            endcase
            inx = (rem != 0);
            q   = q + (up ? 1 : 0);
            if (q * unit >= (longint'(1) << 24))
                r = {x[31], 8'(e + 128), 23'd0};
            else
                r = {x[31], x[30:23], 23'(q * unit - (longint'(1) << 23))};
        end else if (x[30:0] != 31'd0) begin
            inx = 1'b1;
            case (md)
                2'b00:   up = (e == -1) && x[22:0] != 23'd0;
                2'b01:   up = 1'b0;
                2'b10:   up = x[31];
                default: up = !x[31];
            endcase
            r = {x[31], up ? 31'h3F800000 : 31'd0};
        end
    endfunction

    function automatic void ref_int(input logic [31:0] r, output logic [31:0] iv,
                                    output logic inv);
        int     e;
        longint mag, val;
        e   = int'(r[30:23]) - 127;
        inv = 1'b0;
        iv  = 32'd0;
        if (r[30:23] == 8'hFF) begin
            inv = 1'b1;
            iv  = (r[31] && r[22:0] == 23'd0) ? 32'h80000000 : 32'h7FFFFFFF;
        end else if (e < 0) begin
            iv = 32'd0;
        end else if (e > 40) begin
            inv = 1'b1;
            iv  = r[31] ? 32'h80000000 : 32'h7FFFFFFF;
        end else begin
            mag = longint'({1'b1, r[22:0]});
            if (e >= 23) mag = mag << (e - 23);
            else         mag = mag >> (23 - e);
            val = r[31] ? -mag : mag;
            if (val > 64'sd2147483647 || val < -64'sd2147483648) begin
                inv = 1'b1;
                iv  = r[31] ? 32'h80000000 : 32'h7FFFFFFF;
            end else begin
                iv = 32'(val);
            end
        end
    endfunction

    // One clock cycle. Inputs are already driven; checks happen 1 time unit
    // after the falling edge, then the task returns at the next falling edge.
    task automatic tick(input bit has_exp, input logic [31:0] e_data, input logic e_inx,
                        output bit acc);
        bit          en;
        logic [31:0] ed, ei_int, md;
        logic        ex, ei_inv, mi;
        #1;
        en = !m_v2 || out_ready;
        chk("in_ready", in_ready, en);
        chk("out_valid", out_valid, m_v2);
        acc = in_valid && en;
        if (out_valid && out_ready) begin
            if (q_data.size() == 0) begin
                chk("result_without_op", out_valid, 1'b0);
            end else begin
                ed     = q_data.pop_front();
                ex     = q_inx.pop_front();
                ei_int = q_int.pop_front();
                ei_inv = q_inv.pop_front();
                chk("out_data", out_data, ed);
                chk("out_inexact", out_inexact, ex);
`ifdef FROUND_INT_OUT_EN
                chk("int_out", int_out, ei_int);
                chk("int_invalid", int_invalid, ei_inv);
`endif
                n_out++;
            end
        end
        if (acc) begin
            ref_round(in_data, in_mode, md, mi);
            if (has_exp) begin
                md = e_data;
                mi = e_inx;
            end
            ref_int(md, ei_int, ei_inv);
            q_data.push_back(md);
            q_inx.push_back(mi);
            q_int.push_back(ei_int);
            q_inv.push_back(ei_inv);
        end
        if (en) begin
            m_v2 = m_v1;
            m_v1 = in_valid;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        bit acc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (q_data.size() != 0 || m_v1 || m_v2); i++)
            tick(1'b0, 32'd0, 1'b0, acc);
        chk("drain_empty", q_data.size(), 0);
    endtask

    task automatic do_reset();
        rstn     = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_inexact", out_inexact, 1'b0);
`ifdef FROUND_INT_OUT_EN
        chk("rst_int_out", int_out, 32'd0);
        chk("rst_int_invalid", int_invalid, 1'b0);
`endif
        rstn = 1'b1;
        q_data.delete();
        q_inx.delete();
        q_int.delete();
        q_inv.delete();
        m_v1 = 1'b0;
        m_v2 = 1'b0;
        @(negedge clk);
    endtask

    // {mode, operand, expected result, expected inexact}
    typedef struct {
        logic [1:0]  md;
        logic [31:0] x;
        logic [31:0] r;
        logic        inx;
    } vec_t;

    vec_t vecs[$] = '{
        '{2'b10, 32'h40400000, 32'h40400000, 1'b0},
        '{2'b10, 32'hBDCCCCCD, 32'hBF800000, 1'b1},
        '{2'b11, 32'hBDCCCCCD, 32'h80000000, 1'b1},
        '{2'b01, 32'h3DCCCCCD, 32'h00000000, 1'b1},
        '{2'b00, 32'h40200000, 32'h40000000, 1'b1},
        '{2'b00, 32'h40600000, 32'h40800000, 1'b1},
        '{2'b10, 32'hC1480000, 32'hC1500000, 1'b1},
        '{2'b00, 32'h7F800001, 32'h7FC00001, 1'b0},
        '{2'b11, 32'h7F800000, 32'h7F800000, 1'b0},
        '{2'b10, 32'hFF800000, 32'hFF800000, 1'b0},
        '{2'b00, 32'h4B000001, 32'h4B000001, 1'b0},
        '{2'b01, 32'h4B000001, 32'h4B000001, 1'b0},
        '{2'b10, 32'h4B000001, 32'h4B000001, 1'b0},
        '{2'b11, 32'h4B000001, 32'h4B000001, 1'b0},
        '{2'b10, 32'h80000000, 32'h80000000, 1'b0},
        '{2'b11, 32'hBF000000, 32'h80000000, 1'b1},
        '{2'b00, 32'h3F000000, 32'h00000000, 1'b1},
        '{2'b00, 32'h3F400000, 32'h3F800000, 1'b1},
        '{2'b11, 32'h00000001, 32'h3F800000, 1'b1},
        '{2'b00, 32'h3FC00000, 32'h40000000, 1'b1},
        '{2'b01, 32'h4AFFFFFF, 32'h4AFFFFFE, 1'b1},
        '{2'b00, 32'h4AFFFFFF, 32'h4B000000, 1'b1},
        '{2'b01, 32'h4F32D05E, 32'h4F32D05E, 1'b0},
        '{2'b10, 32'hCF000000, 32'hCF000000, 1'b0}
    };

    logic [31:0] stall_ops[6] = '{32'h40200000, 32'hC1480000, 32'h3F400000,
                                  32'h40600000, 32'hBDCCCCCD, 32'h4B000001};

    // Safety net against a hung handshake.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        int idx;
        int n_out0;
        int sel;

        // Reset state
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        in_mode   = 2'b00;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        do_reset();

        // Directed vectors, streamed back to back
        foreach (vecs[i]) begin
            in_valid = 1'b1;
            in_data  = vecs[i].x;
            in_mode  = vecs[i].md;
            tick(1'b1, vecs[i].r, vecs[i].inx, acc);
        end
        drain();

        // Back-to-back stream with a 3-cycle consumer stall
        n_out0 = n_out;
        idx    = 0;
        for (int cyc = 0; cyc < 40 && (idx < 6 || q_data.size() != 0 || m_v1 || m_v2); cyc++) begin
            out_ready = !(cyc >= 3 && cyc < 6);
            in_valid  = (idx < 6);
            in_data   = stall_ops[idx % 6];
            in_mode   = 2'(idx);
            tick(1'b0, 32'd0, 1'b0, acc);
            if (acc) idx++;
        end
        chk("stall_all_results", n_out - n_out0, 6);
        drain();

        // Reset with two operations in flight
        in_valid = 1'b1;
        in_data  = 32'h40200000;
        in_mode  = 2'b00;
        tick(1'b0, 32'd0, 1'b0, acc);
        in_data  = 32'hC1480000;
        in_mode  = 2'b10;
        tick(1'b0, 32'd0, 1'b0, acc);
        do_reset();
        in_valid = 1'b0;
        repeat (4) tick(1'b0, 32'd0, 1'b0, acc);

        // Random traffic with random backpressure and per-operand mode
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            in_mode   = 2'($urandom);
            sel       = $urandom % 8;
            case (sel)
                0:       in_data = $urandom;
                1:       in_data = {1'($urandom), 8'hFF, 23'($urandom % 3)};
                2:       in_data = {1'($urandom), 8'($urandom % 2), 23'($urandom)};
                default: in_data = {1'($urandom), 8'($urandom_range(110, 155)), 23'($urandom)};
            endcase
            tick(1'b0, 32'd0, 1'b0, acc);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
